// File: rtl/instr_fetch_aligner.sv
// instr_fetch_aligner
//   Fetch-side realigner. It issues word-aligned 32-bit fetches and keeps the
//   returned halfwords in a 4-entry queue. From that queue it extracts one
//   16-bit (RVC) or 32-bit instruction per transfer, including 32-bit
//   instructions that straddle a word boundary.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   fetch_req       fetch request (combinational from state)
//   fetch_addr      word address of the request, [1:0] = 2'b00
//   fetch_rvalid    response valid (one per request, at least 1 cycle later)
//   fetch_rdata     response word, little-endian halfwords
//   redirect        one-cycle redirect pulse
//   redirect_pc     new PC (halfword aligned)
//   out_valid       instruction available
//   out_ready       consumer accepts
//   out_instr       instruction; RVC is zero-extended
//   out_compressed  out_instr is a 16-bit instruction
//   out_pc          PC of out_instr
//
// Handshake: an instruction moves when out_valid && out_ready are both high
// at a rising edge. While out_valid is high and out_ready is low, out_instr,
// out_compressed and out_pc do not change. out_valid does not depend on
// out_ready.
module instr_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_rvalid,
  input  logic [31:0] fetch_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_compressed,
  output logic [31:0] out_pc
);

  logic [15:0] q [4];
  logic [15:0] q_next [4];
  logic [15:0] q_shift [4];
  logic [2:0]  count;
  logic [2:0]  count_next;
  logic        pending;
  logic        discard;
  logic        skip_low;
  logic [31:0] pc_q;
  logic [31:0] addr_q;

  logic        head_rvc;
  logic        xfer;
  logic        accept;
  logic [2:0]  pop_n;
  logic [2:0]  push_n;
  logic [2:0]  base;
  logic [15:0] push_lo;
  logic [15:0] push_hi;

  assign head_rvc = (q[0][1:0] != 2'b11);

  // A 32-bit head with only one halfword queued (straddle) stays invalid
  // until the following word is pushed.
  assign out_valid = !redirect &&
                     (((count >= 3'd1) && head_rvc) || (count >= 3'd2));

  assign out_instr      = !out_valid ? 32'h0 :
                          head_rvc   ? {16'h0000, q[0]} : {q[1], q[0]};
  assign out_compressed = out_valid && head_rvc;
  assign out_pc         = pc_q;

  // Issuing only at count <= 2 leaves room for the full response word.
  assign fetch_req  = !pending && (count <= 3'd2) && !redirect;
  assign fetch_addr = addr_q;

  assign xfer   = out_valid && out_ready;
  assign pop_n  = !xfer ? 3'd0 : (head_rvc ? 3'd1 : 3'd2);

  // Responses are dropped while a redirect is in flight or in the
  // redirect cycle itself.
  assign accept = fetch_rvalid && !discard && !redirect;
  assign push_n = !accept ? 3'd0 : (skip_low ? 3'd1 : 3'd2);

  // After a redirect to an odd halfword, the low half of the first word
  // lies before the target PC and is skipped.
  assign push_lo = skip_low ? fetch_rdata[31:16] : fetch_rdata[15:0];
  assign push_hi = fetch_rdata[31:16];

  assign base       = count - pop_n;
  assign count_next = count + push_n - pop_n;

  always_comb begin
    q_shift = q;
    case (pop_n)
      3'd1:    q_shift = '{q[1], q[2], q[3], q[3]};
      3'd2:    q_shift = '{q[2], q[3], q[2], q[3]};
      default: q_shift = q;
    endcase
    q_next = q_shift;
    for (int i = 0; i < 4; i++) begin
      if ((push_n != 3'd0) && (base == 3'(i))) begin
        q_next[i] = push_lo;
      end
      if ((push_n == 3'd2) && ((base + 3'd1) == 3'(i))) begin
        q_next[i] = push_hi;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        q[i] <= 16'h0;
      end
      count    <= 3'd0;
      pending  <= 1'b0;
      discard  <= 1'b0;
      skip_low <= RESET_PC[1];
      pc_q     <= RESET_PC;
      addr_q   <= {RESET_PC[31:2], 2'b00};
    end else if (redirect) begin
      // The outstanding fetch (if its response is not here yet) belongs to
      // the old path; remember to drop it when it arrives.
      count    <= 3'd0;
      pc_q     <= redirect_pc;
      addr_q   <= {redirect_pc[31:2], 2'b00};
      skip_low <= redirect_pc[1];
      discard  <= pending && !fetch_rvalid;
      pending  <= pending && !fetch_rvalid;
    end else begin
      q     <= q_next;
      count <= count_next;
      if (xfer) begin
        pc_q <= pc_q + (head_rvc ? 32'd2 : 32'd4);
      end
      if (fetch_req) begin
        pending <= 1'b1;
        addr_q  <= addr_q + 32'd4;
      end else if (fetch_rvalid) begin
        pending <= 1'b0;
      end
      if (fetch_rvalid) begin
        discard <= 1'b0;
      end
      if (accept && skip_low) begin
        skip_low <= 1'b0;
      end
    end
  end

  a_rvalid_needs_pending: assert property (
    @(posedge clk) disable iff (rst) fetch_rvalid |-> pending
  );

endmodule

// File: tb/tb_instr_fetch_aligner.sv
module tb_instr_fetch_aligner;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_compressed;
  logic [31:0] out_pc;

  instr_fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_req      (fetch_req),
    .fetch_addr     (fetch_addr),
    .fetch_rvalid   (fetch_rvalid),
    .fetch_rdata    (fetch_rdata),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_compressed (out_compressed),
    .out_pc         (out_pc)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model / responder ----------------
  logic [31:0] mem [0:127];
  int          lat;
  logic        outstanding;
  logic [31:0] req_addr;
  int          wait_cnt;

  // Acts 1 time unit after each falling edge, once the main process has
  // driven its inputs for the cycle.
  initial begin
    fetch_rvalid = 1'b0;
    fetch_rdata  = 32'h0;
    outstanding  = 1'b0;
    req_addr     = 32'h0;
    wait_cnt     = 0;
    forever begin
      @(negedge clk);
      #1;
      fetch_rvalid = 1'b0;
      if (rst) begin
        outstanding = 1'b0;
      end else if (outstanding) begin
        if (wait_cnt == 0) begin
          fetch_rvalid = 1'b1;
          fetch_rdata  = mem[req_addr[8:2]];
          outstanding  = 1'b0;
        end else begin
          wait_cnt--;
        end
      end else if (fetch_req) begin
        outstanding = 1'b1;
        req_addr    = fetch_addr;
        wait_cnt    = lat;
      end
    end
  end

  // ---------------- scoreboard ----------------
  localparam int EW = 65;
  logic [EW-1:0] exp_q[$];
  int checks;
  int failures;

  function automatic logic [EW-1:0] mk(input logic c, input logic [31:0] pc,
                                       input logic [31:0] ins);
    return {c, pc, ins};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 128; i++) begin
      mem[i] = 32'h0001_0001;
    end
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic do_reset(input logic ready);
    rst       = 1'b1;
    redirect  = 1'b0;
    out_ready = ready;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a falling edge; compares every transfer against exp_q.
  task automatic run_expect(input int budget);
    int n;
    logic [EW-1:0] e;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      #2;
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        chk("stream_instr", out_instr, e[31:0]);
        chk("stream_pc", out_pc, e[63:32]);
        chk("stream_compressed", {31'b0, out_compressed}, {31'b0, e[64]});
      end
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL stream_timeout: remaining=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0]   w0;
    logic [31:0]   w1;
    int            lat;
    logic [EW-1:0] e0;
    logic [EW-1:0] e1;
    logic [EW-1:0] e2;
  } vec_t;

  vec_t vecs [4];
  logic found;

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b0;
    lat         = 0;
    fill_mem();

    vecs[0] = '{32'h00A0_0093, 32'h0001_0001, 0,
                mk(1'b0, 32'h0, 32'h00A0_0093),
                mk(1'b1, 32'h4, 32'h0000_0001),
                mk(1'b1, 32'h6, 32'h0000_0001)};
    vecs[1] = '{32'h4505_0001, 32'h00A0_0093, 1,
                mk(1'b1, 32'h0, 32'h0000_0001),
                mk(1'b1, 32'h2, 32'h0000_4505),
                mk(1'b0, 32'h4, 32'h00A0_0093)};
    vecs[2] = '{32'h0093_0001, 32'h0001_00A0, 2,
                mk(1'b1, 32'h0, 32'h0000_0001),
                mk(1'b0, 32'h2, 32'h00A0_0093),
                mk(1'b1, 32'h6, 32'h0000_0001)};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0002, 3,
                mk(1'b0, 32'h0, 32'hFFFF_FFFF),
                mk(1'b1, 32'h4, 32'h0000_0002),
                mk(1'b1, 32'h6, 32'h0000_0000)};

    @(negedge clk);

    // ---- reset values and first-response latency ----
    fill_mem();
    mem[0] = 32'h00A0_0093;
    lat = 0;
    do_reset(1'b1);
    #2;
    chk("rst_fetch_req", {31'b0, fetch_req}, 32'h1);
    chk("rst_fetch_addr", fetch_addr, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_compressed", {31'b0, out_compressed}, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    @(negedge clk);
    #2;
    chk("resp_cycle_no_bypass", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    #2;
    chk("resp_plus1_valid", {31'b0, out_valid}, 32'h1);
    chk("resp_plus1_instr", out_instr, 32'h00A0_0093);
    @(negedge clk);

    // ---- table-driven decode vectors ----
    for (int v = 0; v < 4; v++) begin
      fill_mem();
      mem[0] = vecs[v].w0;
      mem[1] = vecs[v].w1;
      lat    = vecs[v].lat;
      do_reset(1'b1);
      #2;
      chk("vec_first_req", {31'b0, fetch_req}, 32'h1);
      chk("vec_first_addr", fetch_addr, 32'h0);
      @(negedge clk);
      exp_q.push_back(vecs[v].e0);
      exp_q.push_back(vecs[v].e1);
      exp_q.push_back(vecs[v].e2);
      run_expect(60);
    end

    // ---- backpressure ----
    fill_mem();
    mem[0] = 32'h00A0_0093;
    mem[1] = 32'h00B0_0113;
    mem[2] = 32'h4505_0001;
    lat = 0;
    do_reset(1'b0);
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      #2;
      if (k >= 2) begin
        chk("bp_valid", {31'b0, out_valid}, 32'h1);
        chk("bp_instr_stable", out_instr, 32'h00A0_0093);
        chk("bp_pc_stable", out_pc, 32'h0);
      end
      if (k >= 4) begin
        chk("bp_no_fetch_when_full", {31'b0, fetch_req}, 32'h0);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    exp_q.push_back(mk(1'b0, 32'h0, 32'h00A0_0093));
    exp_q.push_back(mk(1'b0, 32'h4, 32'h00B0_0113));
    exp_q.push_back(mk(1'b1, 32'h8, 32'h0000_0001));
    exp_q.push_back(mk(1'b1, 32'hA, 32'h0000_4505));
    run_expect(60);

    // ---- redirect with a fetch in flight ----
    fill_mem();
    mem[2]  = 32'h7777_7777;
    mem[65] = 32'h4505_1234;
    mem[66] = 32'h00A0_0093;
    lat = 3;
    do_reset(1'b1);
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      #2;
      if (outstanding && req_addr == 32'h8) found = 1'b1;
      @(negedge clk);
    end
    chk("redir_saw_req8", {31'b0, found}, 32'h1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0106;
    exp_q.push_back(mk(1'b1, 32'h106, 32'h0000_4505));
    exp_q.push_back(mk(1'b0, 32'h108, 32'h00A0_0093));
    #2;
    chk("redir_out_valid", {31'b0, out_valid}, 32'h0);
    chk("redir_fetch_req", {31'b0, fetch_req}, 32'h0);
    @(negedge clk);
    redirect = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      #2;
      if (fetch_req) begin
        found = 1'b1;
        chk("redir_fetch_addr", fetch_addr, 32'h0000_0104);
      end
      @(negedge clk);
    end
    chk("redir_refetch_seen", {31'b0, found}, 32'h1);
    run_expect(60);

    // ---- asynchronous reset mid-stream with three halfwords queued ----
    fill_mem();
    mem[0] = 32'h4505_0001;
    mem[1] = 32'h4505_0001;
    lat = 0;
    do_reset(1'b0);
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    #2;
    chk("mid_valid_before_pop", {31'b0, out_valid}, 32'h1);
    chk("mid_instr_before_pop", out_instr, 32'h0000_0001);
    @(negedge clk);
    out_ready = 1'b0;
    #2;
    chk("mid_pc_after_pop", out_pc, 32'h2);
    chk("mid_instr_after_pop", out_instr, 32'h0000_4505);
    chk("mid_no_fetch_count3", {31'b0, fetch_req}, 32'h0);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("async_rst_addr", fetch_addr, 32'h0);
    chk("async_rst_pc", out_pc, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("restart_fetch_req", {31'b0, fetch_req}, 32'h1);
    chk("restart_fetch_addr", fetch_addr, 32'h0);
    @(negedge clk);
    exp_q.push_back(mk(1'b1, 32'h0, 32'h0000_0001));
    exp_q.push_back(mk(1'b1, 32'h2, 32'h0000_4505));
    exp_q.push_back(mk(1'b1, 32'h4, 32'h0000_0001));
    run_expect(60);

    // ---- report ----
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
